// File: rtl/arith_unit.sv
// Fixed-point arithmetic unit: combinational saturating ADD/SUB/MUL and a
// multi-cycle restoring divider whose quotient is held for the data bank.
module arith_unit #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         ovf,
  output logic         dz
);

  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST      = CW'(N - 1);
  localparam logic [W-1:0]  MAX_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0]  MAX_POS_N = {{FRAC{1'b0}}, MAX_POS};
  localparam logic [N-1:0]  MIN_NEG_N = {{FRAC{1'b0}}, MIN_NEG};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [N-1:0]  dvd_reg;
  logic [W-1:0]  rem_reg;
  logic [W-1:0]  dvs_reg;
  logic [W-1:0]  quot_reg;
  logic          neg_reg, a_neg_reg, bz_reg, ovf_div_reg, dz_reg;

  // Combinational ADD/SUB/MUL with one guard bit / full-width product
  logic signed [W:0]     sum_full, diff_full;
  logic signed [2*W-1:0] prod_full, prod_shr;

  assign sum_full  = $signed({a[W-1], a}) + $signed({b[W-1], b});
  assign diff_full = $signed({a[W-1], a}) - $signed({b[W-1], b});
  assign prod_full = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_shr  = prod_full >>> FRAC;

  always_comb begin
    result = quot_reg;
    ovf    = ovf_div_reg;
    case (op)
      2'b00: begin
        ovf    = (sum_full[W] != sum_full[W-1]);
        result = ovf ? (sum_full[W] ? MIN_NEG : MAX_POS) : sum_full[W-1:0];
      end
      2'b01: begin
        ovf    = (diff_full[W] != diff_full[W-1]);
        result = ovf ? (diff_full[W] ? MIN_NEG : MAX_POS) : diff_full[W-1:0];
      end
      2'b10: begin
        ovf    = (prod_shr[2*W-1:W-1] != {(W+1){prod_shr[2*W-1]}});
        result = ovf ? (prod_shr[2*W-1] ? MIN_NEG : MAX_POS) : prod_shr[W-1:0];
      end
      default: ;
    endcase
  end

  // Restoring divider datapath: dividend register shifts quotient bits in at the LSB
  logic [W-1:0] a_mag, b_mag;
  logic [W:0]   rem_shift, rem_diff, rem_next;
  logic         q_bit, rem_unused;
  logic [N-1:0] dvd_next;
  logic [W-1:0] quot_fin;
  logic         ovf_fin;
  logic         launch;

  assign a_mag      = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag      = b[W-1] ? (~b + W'(1)) : b;
  assign rem_shift  = {rem_reg, dvd_reg[N-1]};
  assign q_bit      = (rem_shift >= {1'b0, dvs_reg});
  assign rem_diff   = rem_shift - {1'b0, dvs_reg};
  assign rem_next   = q_bit ? rem_diff : rem_shift;
  // remainder stays below the divisor, so the top bit is always zero
  assign rem_unused = rem_next[W];
  assign dvd_next   = {dvd_reg[N-2:0], q_bit};
  assign launch     = (state_reg == IDLE) && start && (op == 2'b11);

  always_comb begin
    quot_fin = dvd_next[W-1:0];
    ovf_fin  = 1'b0;
    if (bz_reg) begin
      quot_fin = a_neg_reg ? MIN_NEG : MAX_POS;
      ovf_fin  = 1'b1;
    end else if (neg_reg) begin
      if (dvd_next > MIN_NEG_N) begin
        quot_fin = MIN_NEG;
        ovf_fin  = 1'b1;
      end else begin
        quot_fin = ~dvd_next[W-1:0] + W'(1);
      end
    end else if (dvd_next > MAX_POS_N) begin
      quot_fin = MAX_POS;
      ovf_fin  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DONE never looks at start, so a held start cannot relaunch on the done cycle
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (launch) state_next = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (count_reg == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      dvd_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      quot_reg    <= '0;
      neg_reg     <= 1'b0;
      a_neg_reg   <= 1'b0;
      bz_reg      <= 1'b0;
      ovf_div_reg <= 1'b0;
      dz_reg      <= 1'b0;
    end else if (launch) begin
      count_reg <= '0;
      dvd_reg   <= {a_mag, {FRAC{1'b0}}};
      rem_reg   <= '0;
      dvs_reg   <= b_mag;
      neg_reg   <= a[W-1] ^ b[W-1];
      a_neg_reg <= a[W-1];
      bz_reg    <= (b == '0);
      dz_reg    <= 1'b0;
    end else if (state_reg == BUSY) begin
      count_reg <= count_reg + CW'(1);
      dvd_reg   <= dvd_next;
      rem_reg   <= rem_next[W-1:0];
      if (count_reg == LAST) begin
        quot_reg    <= quot_fin;
        ovf_div_reg <= ovf_fin;
        dz_reg      <= bz_reg;
      end
    end
  end

  assign dz = dz_reg;

endmodule

// File: tb/tb_arith_unit.sv
// Directed-vector bench for arith_unit: combinational ops, DIV latency,
// saturation, divide by zero, operand/start immunity and async abort.
module tb_arith_unit;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int N    = W + FRAC;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] result;
  logic         done, busy, ovf, dz;

  int checks = 0;
  int errors = 0;

  arith_unit #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic comb_op(input string tag, input logic [1:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [15:0] er, input logic eo);
    @(negedge clk);
    op = o; a = aa; b = bb;
    #1;
    check({tag, " result"}, {16'h0, result}, {16'h0, er});
    check({tag, " ovf"}, {31'h0, ovf}, {31'h0, eo});
  endtask

  // Returns at the negedge following the launch edge
  task automatic launch_div(input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    op = 2'b11; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    check("div busy after launch", {31'h0, busy}, 32'h1);
  endtask

  // Counts edges since launch until done is seen; 40-edge bound
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic div_case(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [15:0] eq, input logic eo, input logic edz);
    int cyc;
    launch_div(aa, bb);
    start = 1'b0;
    wait_done(cyc);
    check({tag, " latency"}, cyc, N);
    check({tag, " quotient"}, {16'h0, result}, {16'h0, eq});
    check({tag, " ovf"}, {31'h0, ovf}, {31'h0, eo});
    check({tag, " dz"}, {31'h0, dz}, {31'h0, edz});
  endtask

  initial begin
    int cyc;
    int pulses;
    int done_at;

    // Reset state, DIV view shows the cleared quotient
    op = 2'b11;
    #12;
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst done", {31'h0, done}, 32'h0);
    check("rst result", {16'h0, result}, 32'h0);
    check("rst dz", {31'h0, dz}, 32'h0);
    check("rst ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    comb_op("add", 2'b00, 16'h0180, 16'h0200, 16'h0380, 1'b0);
    comb_op("sub sat", 2'b01, 16'h8000, 16'h0100, 16'h8000, 1'b1);
    comb_op("add sat", 2'b00, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
    comb_op("mul", 2'b10, 16'h0180, 16'h0200, 16'h0300, 1'b0);
    comb_op("mul sat", 2'b10, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
    comb_op("mul neg", 2'b10, 16'hFE80, 16'h0200, 16'hFD00, 1'b0);

    // start with a non-DIV op does nothing
    @(negedge clk);
    op = 2'b00; a = 16'h0001; b = 16'h0002; start = 1'b1;
    @(negedge clk);
    check("start add busy", {31'h0, busy}, 32'h0);
    check("start add result", {16'h0, result}, 32'h0003);
    start = 1'b0;

    // DIV with start held through done: no relaunch on the done edge,
    // then the next DIV is taken on the following edge
    launch_div(16'h0300, 16'h0200);
    wait_done(cyc);
    check("div held latency", cyc, N);
    check("div held quotient", {16'h0, result}, 32'h0180);
    check("div held ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    check("no relaunch busy", {31'h0, busy}, 32'h0);
    check("no relaunch done", {31'h0, done}, 32'h0);
    a = 16'h0100; b = 16'h0300;
    @(negedge clk);
    check("back2back busy", {31'h0, busy}, 32'h1);
    start = 1'b0;
    wait_done(cyc);
    check("back2back latency", cyc, N);
    check("back2back quotient", {16'h0, result}, 32'h0055);

    div_case("div neg", 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0);
    div_case("div zero", 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    div_case("div zero neg", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1);
    div_case("div sat", 16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0);

    // Operand changes and start toggling during BUSY
    launch_div(16'h0300, 16'h0200);
    pulses  = 0;
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      start = (i >= 2 && i <= 12) ? i[0] : 1'b0;
      if (i >= 3 && i <= 12) begin
        a = 16'h1234 + 16'(i);
        b = 16'h0007;
      end
      @(negedge clk);
      if (done) begin
        pulses++;
        done_at = i;
      end
    end
    check("noise done pulses", pulses, 1);
    check("noise done edge", done_at, N);
    check("noise quotient", {16'h0, result}, 32'h0180);

    // Quotient persists across other ops
    comb_op("persist add", 2'b00, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    @(negedge clk);
    op = 2'b11;
    #1;
    check("persist div", {16'h0, result}, 32'h0180);

    // Async reset at iteration 10 aborts the divide
    launch_div(16'h0100, 16'h0300);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort quotient", {16'h0, result}, 32'h0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", pulses, 0);
    div_case("after abort", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
